// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter with line locking in front of one byte-serial UART TX engine.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/data    per-requester byte offer; byte i lives in req_data[8i+7:8i]
//   req_ready         one-hot accept strobe (valid && ready on a rising edge = accepted)
//   tx_data/tx_we     byte and write strobe to the TX engine
//   tx_ready          engine idle
//   grant_id          current or last owner
//   lock_active       a requester owns the engine
//   busy              FSM not idle
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ID_W         = 2,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [8*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [7:0]          tx_data,
  output logic                tx_we,
  input  logic                tx_ready,
  output logic [ID_W-1:0]     grant_id,
  output logic                lock_active,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] winner, pick;
  logic [TO_W-1:0] cnt;
  logic [7:0] pick_data;
  logic any_req, take, expired;
  // Scan from the lowest priority (grant_id itself) up to grant_id+1 so the
  // last hit, i.e. the one closest after grant_id, wins.
  always_comb begin
    winner = grant_id;
    any_req = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = int'(grant_id) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        winner = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end
  // In HOLD only the owner can be served; in IDLE the round-robin winner.
  assign pick = (state == HOLD) ? grant_id : winner;
  assign take = rst_n && ((state == IDLE && tx_ready && any_req) || (state == HOLD && req_valid[grant_id]));
  assign expired = (cnt == TO_W'(LOCK_TIMEOUT - 1));
  assign req_ready = take ? (N_REQ'(1) << pick) : '0;
  assign busy = (state != IDLE);
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (ID_W'(i) == pick) pick_data = req_data[8*i +: 8];
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = take ? LOAD : IDLE;
      LOAD:  state_nx = tx_ready ? LOAD : DRAIN;
      DRAIN: state_nx = !tx_ready ? DRAIN : (tx_data == 8'h0A) ? IDLE : HOLD;
      HOLD:  state_nx = take ? LOAD : expired ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_we       <= 1'b0;
      tx_data     <= '0;
      grant_id    <= ID_W'(N_REQ - 1);
      lock_active <= 1'b0;
      cnt         <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        tx_data     <= pick_data;
        grant_id    <= pick;
        tx_we       <= 1'b1;
        lock_active <= 1'b1;
      end
      if (state == LOAD && !tx_ready) tx_we <= 1'b0;
      if (state == DRAIN && tx_ready) begin
        cnt <= '0;
        if (tx_data == 8'h0A) lock_active <= 1'b0;
      end
      // An owner request on the expiry cycle is taken above, keeping the lock.
      if (state == HOLD && !take) begin
        cnt <= cnt + TO_W'(1);
        if (expired) lock_active <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a line-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [7:0] tx_data;
  logic tx_we;
  logic tx_ready = 1'b1;
  logic [1:0] grant_id;
  logic lock_active, busy;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;
  logic [7:0] q [N][$];
  logic [7:0] tx_log [$];
  int acc_id [$];
  int acc_cyc [$];
  logic [N-1:0] acc;
  uart_tx_arbiter #(.N_REQ(N), .ID_W(2), .LOCK_TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_we(tx_we), .tx_ready(tx_ready),
    .grant_id(grant_id), .lock_active(lock_active), .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  // Requesters: present the head of each queue, pop it once accepted.
  // Inputs change on the falling edge, so valid&&ready seen 1 unit later is
  // what the next rising edge samples.
  initial begin
    req_valid = '0;
    req_data = '0;
    acc = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
      for (int i = 0; i < N; i++) begin
        req_valid[i] = q[i].size() > 0;
        req_data[8*i +: 8] = q[i].size() > 0 ? q[i][0] : 8'h00;
      end
      #1;
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc + 1);
        end
    end
  end
  // TX engine: takes a byte when idle and tx_we is high, stays busy 1..4 cycles.
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_ready = 1'b1;
        lat = 0;
      end else if (tx_ready && tx_we) begin
        tx_log.push_back(tx_data);
        tx_ready = 1'b0;
        lat = $urandom_range(1, 4);
      end else if (!tx_ready) begin
        lat--;
        if (lat == 0) begin
          tx_ready = 1'b1;
          rise_cyc = cyc + 1;
        end
      end
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    repeat (2) @(negedge clk);
    tx_log.delete();
    acc_id.delete();
    acc_cyc.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic settle(input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      bit empty;
      @(negedge clk);
      #2;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) empty = 1'b0;
      if (empty && !busy && tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    q[0].push_back(8'h41);
    repeat (2) @(negedge clk);
    #2;
    checks++; if (tx_we !== 1'b0) begin errors++; $display("FAIL reset_tx_we: got %b want 0", tx_we); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant_id: got %0d want 3", grant_id); end
    checks++; if (lock_active !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", lock_active); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000 (valid=%b)", req_ready, req_valid); end
  endtask
  task automatic test_single();
    bit ok;
    do_reset();
    q[0] = '{8'h41, 8'h0A};
    settle(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got timeout want idle"); end
    checks++; if (tx_log.size() != 2) begin errors++; $display("FAIL single_count: got %0d want 2", tx_log.size()); end
    checks++; if (tx_log.size() < 1 || tx_log[0] !== 8'h41) begin errors++; $display("FAIL single_byte0: got %p want 41", tx_log); end
    checks++; if (tx_log.size() < 2 || tx_log[1] !== 8'h0A) begin errors++; $display("FAIL single_byte1: got %p want 0a", tx_log); end
    checks++; if (lock_active !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got lock=%b busy=%b want 0 0", lock_active, busy); end
  endtask
  task automatic test_line_lock();
    bit ok;
    logic [7:0] exp [4];
    exp = '{8'h61, 8'h62, 8'h0A, 8'h31};
    do_reset();
    q[0] = '{8'h61, 8'h62, 8'h0A};
    q[1] = '{8'h31};
    settle(1000, ok);
    checks++; if (!ok || tx_log.size() != 4) begin errors++; $display("FAIL lock_count: got %0d bytes ok=%b want 4", tx_log.size(), ok); end
    for (int k = 0; k < 4 && k < tx_log.size(); k++) begin
      checks++; if (tx_log[k] !== exp[k]) begin errors++; $display("FAIL lock_order[%0d]: got %h want %h", k, tx_log[k], exp[k]); end
    end
    checks++; if (acc_id.size() != 4 || acc_id[3] != 1) begin errors++; $display("FAIL lock_req1_last: got ids %p want 0,0,0,1", acc_id); end
  endtask
  task automatic test_round_robin();
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) q[i] = '{8'h0A, 8'h0A, 8'h0A};
    for (int c = 0; c < 2000 && acc_id.size() < 6; c++) @(negedge clk);
    #2;
    checks++; if (acc_id.size() < 6) begin errors++; $display("FAIL rr_progress: got %0d grants want 6", acc_id.size()); end
    for (int k = 0; k < 6 && k < acc_id.size(); k++) begin
      checks++; if (acc_id[k] != k % N) begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, acc_id[k], k % N); end
    end
    settle(2000, ok);
  endtask
  task automatic test_timeout();
    bit ok;
    int r;
    do_reset();
    q[2] = '{8'h58};
    q[3] = '{8'h33};
    for (int c = 0; c < 500 && acc_id.size() < 2; c++) begin
      @(negedge clk);
      #2;
    end
    r = rise_cyc;
    // HOLD spans TO cycles after the DRAIN exit edge, req_ready shows on the
    // next (IDLE) cycle and the byte is taken on the edge after that.
    checks++; if (acc_id.size() < 2 || acc_id[1] != 3) begin errors++; $display("FAIL timeout_id: got %p want 2,3", acc_id); end
    checks++; if (acc_cyc.size() < 2 || acc_cyc[1] != r + TO + 1) begin errors++; $display("FAIL timeout_cycle: got %0d want %0d", acc_cyc.size() < 2 ? -1 : acc_cyc[1], r + TO + 1); end
    settle(500, ok);
    checks++; if (!ok || lock_active !== 1'b0) begin errors++; $display("FAIL timeout_release: got ok=%b lock=%b want 1 0", ok, lock_active); end
  endtask
  task automatic test_timeout_race();
    bit ok;
    int r;
    do_reset();
    q[2] = '{8'h58};
    q[3] = '{8'h33};
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      #2;
      if (tx_log.size() == 1 && tx_ready) break;
    end
    r = rise_cyc;
    for (int c = 0; c < 100 && cyc < r + TO - 1; c++) begin
      @(posedge clk);
      #1;
    end
    q[2].push_back(8'h59);
    settle(1000, ok);
    checks++; if (acc_id.size() < 2 || acc_id[1] != 2) begin errors++; $display("FAIL race_owner: got ids %p want 2,2,3", acc_id); end
    checks++; if (acc_cyc.size() < 2 || acc_cyc[1] != r + TO) begin errors++; $display("FAIL race_cycle: got %0d want %0d", acc_cyc.size() < 2 ? -1 : acc_cyc[1], r + TO); end
    checks++; if (tx_log.size() != 3 || tx_log[1] !== 8'h59 || tx_log[2] !== 8'h33) begin errors++; $display("FAIL race_order: got %p want 58,59,33", tx_log); end
  endtask
  task automatic test_async_reset();
    bit ok;
    do_reset();
    q[0] = '{8'h41, 8'h42};
    q[1] = '{8'h31};
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (tx_we) break;
    end
    checks++; if (tx_we !== 1'b1) begin errors++; $display("FAIL areset_load: got tx_we=%b want 1", tx_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_we !== 1'b0) begin errors++; $display("FAIL areset_we_drop: got %b want 0", tx_we); end
    checks++; if (grant_id !== 2'd3 || busy !== 1'b0 || lock_active !== 1'b0) begin errors++; $display("FAIL areset_state: got gid=%0d busy=%b lock=%b want 3 0 0", grant_id, busy, lock_active); end
    repeat (2) @(negedge clk);
    tx_log.delete();
    acc_id.delete();
    acc_cyc.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle(1000, ok);
    checks++; if (acc_id.size() < 1 || acc_id[0] != 0) begin errors++; $display("FAIL areset_regrant: got ids %p want 0 first", acc_id); end
    checks++; if (tx_log.size() != 2 || tx_log[0] !== 8'h42 || tx_log[1] !== 8'h31) begin errors++; $display("FAIL areset_order: got %p want 42,31", tx_log); end
  endtask
  task automatic test_random(input int rounds);
    for (int n = 0; n < rounds; n++) begin
      logic [7:0] s [N][$];
      logic [7:0] exp_b [$];
      int exp_id [$];
      int last, o;
      logic [7:0] b;
      bit done;
      do_reset();
      for (int i = 0; i < N; i++) begin
        int len;
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++)
          s[i].push_back($urandom_range(0, 3) == 0 ? 8'h0A : 8'($urandom_range(0, 255)));
        q[i] = s[i];
      end
      // Reference: the owner streams until a newline or until it runs dry
      // (timeout); the next owner is the first requester with data after it.
      last = N - 1;
      forever begin
        o = -1;
        for (int k = 1; k <= N; k++)
          if (o < 0 && s[(last + k) % N].size() > 0) o = (last + k) % N;
        if (o < 0) break;
        do begin
          b = s[o].pop_front();
          exp_b.push_back(b);
          exp_id.push_back(o);
        end while (b != 8'h0A && s[o].size() > 0);
        last = o;
      end
      done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
        @(negedge clk);
        #2;
        checks++; if (!$onehot0(req_ready) || (req_ready & ~req_valid) != 0 || (req_ready != 0 && tx_we)) begin errors++; $display("FAIL rand_ready_rule: got ready=%b valid=%b we=%b", req_ready, req_valid, tx_we); end
        done = !busy && tx_ready && tx_log.size() == exp_b.size();
      end
      checks++; if (!done) begin errors++; $display("FAIL rand_done[%0d]: got %0d bytes want %0d", n, tx_log.size(), exp_b.size()); end
      for (int k = 0; k < exp_b.size() && k < tx_log.size(); k++) begin
        checks++; if (tx_log[k] !== exp_b[k] || k >= acc_id.size() || acc_id[k] != exp_id[k]) begin errors++; $display("FAIL rand_seq[%0d][%0d]: got %h from %0d want %h from %0d", n, k, tx_log[k], k < acc_id.size() ? acc_id[k] : -1, exp_b[k], exp_id[k]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_line_lock();
    test_round_robin();
    test_timeout();
    test_timeout_race();
    test_async_reset();
    test_random(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
